// File: rtl/resp_pkg.sv
// Shared types, default widths and helpers for the req/ack responder.
// Optional checks are enabled with the RESP_ASSERT_EN macro.
package resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        BURST
    } resp_state_t;

    localparam int RESP_DATA_W  = 8;
    localparam int RESP_SEQ_W   = 4;
    localparam int RESP_BURST_W = 3;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] max
    );
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/resp_sat_counter.sv
// Saturating counter with clear and load-to-one, used for burst length.
// Synchronous active-low reset.
module resp_sat_counter
    import resp_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [31:0] MAX = 32'((1 << W) - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= W'(1);
        end else if (inc) begin
            cnt <= W'(sat_inc(32'(cnt), MAX));
        end
    end

endmodule

// File: rtl/req_ack_responder.sv
// Responder for "req |-> ##1 ack": acks each request one cycle later.
// Define RESP_ASSERT_EN to compile in the protocol assertions and cover.
module req_ack_responder
    import resp_pkg::*;
#(
    parameter int DATA_W  = RESP_DATA_W,
    parameter int SEQ_W   = RESP_SEQ_W,
    parameter int BURST_W = RESP_BURST_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               req,
    input  logic [DATA_W-1:0]  req_data,
    output logic               ack,
    output logic [DATA_W-1:0]  ack_data,
    output logic [SEQ_W-1:0]   ack_seq,
    output logic [BURST_W-1:0] burst_len,
    output logic [DATA_W-1:0]  csum,
    output logic               busy
);

    resp_state_t      state;
    resp_state_t      state_nxt;
    logic [SEQ_W-1:0] seq_nxt;
    logic             from_idle;

    assign from_idle = (state == IDLE);

    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            IDLE:    state_nxt = req ? ACK : IDLE;
            ACK:     state_nxt = req ? BURST : IDLE;
            BURST:   state_nxt = req ? BURST : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= IDLE;
            ack_data <= '0;
            ack_seq  <= '0;
            seq_nxt  <= '0;
            csum     <= '0;
        end else begin
            state <= state_nxt;
            if (req) begin
                ack_data <= req_data + DATA_W'(1);
                ack_seq  <= seq_nxt;
                seq_nxt  <= seq_nxt + SEQ_W'(1);
                csum     <= from_idle ? req_data : (csum ^ req_data);
            end else begin
                csum <= '0;
            end
        end
    end

    // ack and busy come straight from the state register
    assign ack  = (state != IDLE);
    assign busy = ack;

    resp_sat_counter #(
        .W (BURST_W)
    ) u_burst (
        .clk   (CLK),
        .rst_n (RESET),
        .clr   (!req),
        .load1 (req && from_idle),
        .inc   (req && !from_idle),
        .cnt   (burst_len)
    );

`ifdef RESP_ASSERT_EN
    a_req_ack : assert property (
        @(posedge CLK) disable iff (!RESET) req |-> ##1 ack
    );

    a_ack_req : assert property (
        @(posedge CLK) disable iff (!RESET) ack |-> $past(req)
    );

    c_burst_sat : cover property (
        @(posedge CLK) disable iff (!RESET)
            burst_len == BURST_W'((1 << BURST_W) - 1)
    );
`endif

endmodule
